// File: rtl/sdram_arbiter.sv
// sdram_arbiter: fixed-priority arbiter of N_REQ SDRAM clients onto the single SDRAMBus request port
//   i_clk, i_rst                    clock and asynchronous active-high reset
//   req_read/write/addr/writedata   per-client requests, held until that client's req_finished
//   req_readdata, req_finished      shared read data and one-hot completion pulse to the granted client
//   sdram_read/write/addr/writedata registered command held for the whole transaction
//   sdram_readdata, sdram_finished  response from the bus
//   o_grant, o_busy, o_timeout      last grant index, BUSY flag, sticky watchdog abort
module sdram_arbiter #(
  parameter int N_REQ   = 5,
  parameter int TIMEOUT = 4096
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   req_read,
  input  logic [N_REQ-1:0]   req_write,
  input  logic [N_REQ*23-1:0] req_addr,
  input  logic [N_REQ*32-1:0] req_writedata,
  output logic [31:0]        req_readdata,
  output logic [N_REQ-1:0]   req_finished,
  output logic               sdram_read,
  output logic               sdram_write,
  output logic [22:0]        sdram_addr,
  output logic [31:0]        sdram_writedata,
  input  logic [31:0]        sdram_readdata,
  input  logic               sdram_finished,
  output logic [2:0]         o_grant,
  output logic               o_busy,
  output logic               o_timeout
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  state_t state_q, state_d;
  logic [15:0] wd_q, wd_d;
  logic [2:0] grant_q, grant_d;
  logic rd_q, rd_d, wr_q, wr_d, to_q, to_d;
  logic [22:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [N_REQ-1:0] req;
  logic [2:0] g;
  logic busy, expire, done;
  assign req = req_read | req_write;
  assign busy = state_q == BUSY;
  // a real completion in the last watchdog cycle wins over the abort
  assign expire = busy && !sdram_finished && wd_q == 16'(TIMEOUT - 1);
  assign done = busy && (sdram_finished || expire);
  assign req_finished = done ? N_REQ'(1) << grant_q : '0;
  assign req_readdata = busy && sdram_finished ? sdram_readdata : '0;
  assign sdram_read = rd_q;
  assign sdram_write = wr_q;
  assign sdram_addr = addr_q;
  assign sdram_writedata = wdata_q;
  assign o_grant = grant_q;
  assign o_busy = busy;
  assign o_timeout = to_q;
  always_comb begin
    g = '0;
    for (int i = N_REQ - 1; i >= 0; i--) g = req[i] ? 3'(i) : g;
  end
  always_comb begin
    state_d = state_q;
    wd_d = wd_q;
    grant_d = grant_q;
    rd_d = rd_q;
    wr_d = wr_q;
    to_d = to_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = BUSY;
        wd_d = '0;
        grant_d = g;
        wr_d = req_write[g];
        rd_d = req_read[g] & ~req_write[g];
        addr_d = req_addr[23*g +: 23];
        wdata_d = req_writedata[32*g +: 32];
      end
      BUSY: begin
        wd_d = wd_q + 16'd1;
        to_d = to_q | expire;
        rd_d = done ? 1'b0 : rd_q;
        wr_d = done ? 1'b0 : wr_q;
        state_d = done ? RELEASE : BUSY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      wd_q <= '0;
      grant_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      to_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wd_q <= wd_d;
      grant_q <= grant_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      to_q <= to_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: table-driven transactions with a completion scoreboard, plus reset and spurious-finish sequences
module tb_sdram_arbiter;
  localparam int N = 5;
  localparam int TO = 16;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic [N-1:0] req_read = '0;
  logic [N-1:0] req_write = '0;
  logic [N*23-1:0] req_addr;
  logic [N*32-1:0] req_writedata;
  logic [31:0] req_readdata;
  logic [N-1:0] req_finished;
  logic sdram_read, sdram_write;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_writedata;
  logic [31:0] sdram_readdata = 32'hBAD0BAD0;
  logic sdram_finished = 1'b0;
  logic [2:0] o_grant;
  logic o_busy, o_timeout;
  int n_vec = 0;
  int n_bad = 0;
  logic to_exp = 1'b0;
  typedef struct {
    logic [N-1:0] rd, wr, intr;
    logic [2:0] g;
    logic e_rd, e_wr;
    logic [22:0] e_addr;
    logic [31:0] e_wdata;
    int lat;
    logic [31:0] rdata;
  } vec_t;
  typedef struct {
    logic [N-1:0] fin;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[9];
  logic [22:0] caddr[N];
  logic [31:0] cdata[N];
  sdram_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_writedata(req_writedata),
    .req_readdata(req_readdata), .req_finished(req_finished),
    .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_addr(sdram_addr), .sdram_writedata(sdram_writedata),
    .sdram_readdata(sdram_readdata), .sdram_finished(sdram_finished),
    .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic run(input vec_t v);
    int fc;
    exp_t e;
    fc = v.lat < 0 ? TO : v.lat + 1;
    req_read |= v.rd;
    req_write |= v.wr;
    e.fin = N'(1) << v.g;
    e.rd = v.lat < 0 ? 32'h0 : v.rdata;
    sb.push_back(e);
    for (int c = 1; c <= fc; c++) begin
      @(negedge i_clk);
      if (c == 2) req_read |= v.intr;
      if (c == fc && v.lat >= 0) begin
        sdram_finished = 1'b1;
        sdram_readdata = v.rdata;
      end
      #1;
      if (c == 1) begin
        chk("grant", 64'(o_grant), 64'(v.g));
        chk("cmd", 64'({sdram_read, sdram_write}), 64'({v.e_rd, v.e_wr}));
        chk("addr", 64'(sdram_addr), 64'(v.e_addr));
        chk("wdata", 64'(sdram_writedata), 64'(v.e_wdata));
        chk("busy", 64'(o_busy), 64'd1);
      end
      if (c < fc) begin
        chk("no_fin", 64'(req_finished), 64'd0);
        chk("rdata_gated", 64'(req_readdata), 64'd0);
        if (c > 1) chk("addr_hold", 64'(sdram_addr), 64'(v.e_addr));
      end else if (sb.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("fin", 64'(req_finished), 64'(e.fin));
        chk("rdata", 64'(req_readdata), 64'(e.rd));
      end
    end
    if (v.lat < 0) to_exp = 1'b1;
    @(negedge i_clk);
    sdram_finished = 1'b1;
    sdram_readdata = 32'h5A5A5A5A;
    req_read &= ~(N'(1) << v.g);
    req_write &= ~(N'(1) << v.g);
    #1;
    chk("rel_cmd", 64'({sdram_read, sdram_write}), 64'd0);
    chk("rel_busy", 64'(o_busy), 64'd0);
    chk("rel_fin", 64'(req_finished), 64'd0);
    chk("rel_rdata", 64'(req_readdata), 64'd0);
    chk("timeout_flag", 64'(o_timeout), 64'(to_exp));
    @(negedge i_clk);
    sdram_finished = 1'b0;
    sdram_readdata = 32'hBAD0BAD0;
    #1;
    chk("idle_cmd", 64'({sdram_read, sdram_write}), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    caddr = '{23'h000123, 23'h000010, 23'h2ABCDE, 23'h7FFFFF, 23'h000020};
    cdata = '{32'h0BADF00D, 32'hA5A5A5A5, 32'h12345678, 32'hCAFEF00D, 32'h0F0F0F0F};
    for (int i = 0; i < N; i++) begin
      req_addr[23*i +: 23] = caddr[i];
      req_writedata[32*i +: 32] = cdata[i];
    end
    tbl[0] = '{5'b00001, 5'b00000, 5'b00000, 3'd0, 1'b1, 1'b0, 23'h000123, 32'h0BADF00D, 4, 32'hDEADBEEF};
    tbl[1] = '{5'b10000, 5'b00010, 5'b00000, 3'd1, 1'b0, 1'b1, 23'h000010, 32'hA5A5A5A5, 3, 32'h11111111};
    tbl[2] = '{5'b10000, 5'b00000, 5'b00000, 3'd4, 1'b1, 1'b0, 23'h000020, 32'h0F0F0F0F, 2, 32'h22222222};
    tbl[3] = '{5'b01000, 5'b00000, 5'b00001, 3'd3, 1'b1, 1'b0, 23'h7FFFFF, 32'hCAFEF00D, 6, 32'h33333333};
    tbl[4] = '{5'b00001, 5'b00000, 5'b00000, 3'd0, 1'b1, 1'b0, 23'h000123, 32'h0BADF00D, 0, 32'h44444444};
    tbl[5] = '{5'b00100, 5'b00100, 5'b00000, 3'd2, 1'b0, 1'b1, 23'h2ABCDE, 32'h12345678, 2, 32'h55555555};
    tbl[6] = '{5'b00010, 5'b00000, 5'b00000, 3'd1, 1'b1, 1'b0, 23'h000010, 32'hA5A5A5A5, -1, 32'h0};
    tbl[7] = '{5'b00000, 5'b10000, 5'b00000, 3'd4, 1'b0, 1'b1, 23'h000020, 32'h0F0F0F0F, 3, 32'h77777777};
    tbl[8] = '{5'b00100, 5'b00000, 5'b00000, 3'd2, 1'b1, 1'b0, 23'h2ABCDE, 32'h12345678, TO - 1, 32'h99999999};
    #1 i_rst = 1'b1;
    #1;
    chk("rst_cmd", 64'({sdram_read, sdram_write}), 64'd0);
    chk("rst_addr", 64'(sdram_addr), 64'd0);
    chk("rst_wdata", 64'(sdram_writedata), 64'd0);
    chk("rst_flags", 64'({o_grant, o_busy, o_timeout}), 64'd0);
    chk("rst_fin", 64'(req_finished), 64'd0);
    chk("rst_rdata", 64'(req_readdata), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    sdram_finished = 1'b1;
    #1;
    chk("spur_idle_fin", 64'(req_finished), 64'd0);
    chk("spur_idle_rdata", 64'(req_readdata), 64'd0);
    @(negedge i_clk);
    sdram_finished = 1'b0;
    #1;
    chk("spur_idle_busy", 64'(o_busy), 64'd0);
    for (int i = 0; i < 9; i++) run(tbl[i]);
    req_read = 5'b00100;
    @(negedge i_clk);
    #1;
    chk("pre_rst_busy", 64'({o_busy, sdram_read}), 64'b11);
    #2 i_rst = 1'b1;
    #1 sdram_finished = 1'b1;
    #1;
    chk("arst_cmd", 64'({sdram_read, sdram_write}), 64'd0);
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_fin", 64'(req_finished), 64'd0);
    chk("arst_timeout", 64'(o_timeout), 64'd0);
    req_read = '0;
    @(negedge i_clk);
    i_rst = 1'b0;
    sdram_finished = 1'b0;
    to_exp = 1'b0;
    run(tbl[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Arbitrates the five SDRAM clients (play, record, pitch, mix, load) onto the single request port of `SDRAMBus`. It replaces the OR-combined address and command wiring in `AcappellaCore`. It grants one client at a time by fixed priority and holds the grant until the bus reports completion. It registers and holds the granted command for the whole transaction, routes read data and the completion pulse back to the granted client only, and runs a watchdog so that a stalled transaction cannot hang the system.

## Interface
Parameters:
- `N_REQ`, default 5: number of clients. Index 0 = play, 1 = record, 2 = pitch, 3 = mix, 4 = load. A lower index has higher priority.
- `TIMEOUT`, default 4096: maximum number of cycles in BUSY before the transaction is aborted. Legal range 2..65535.

Ports:
- `i_clk`  in  1: the single clock.
- `i_rst`  in  1: reset, asynchronous and active-high.
- `req_read`  in  N_REQ: per-client read request. Held high until that client's `req_finished` pulse.
- `req_write`  in  N_REQ: per-client write request. Same hold rule as `req_read`.
- `req_addr`  in  N_REQ*23: client i address in bits [23i+22:23i].
- `req_writedata`  in  N_REQ*32: client i write data in bits [32i+31:32i].
- `req_readdata`  out  32: read data, shared by all clients. Valid only in a cycle where that client's `req_finished` bit is high.
- `req_finished`  out  N_REQ: one-hot, one-cycle completion pulse to the granted client.
- `sdram_read`  out  1: read command to `SDRAMBus`.
- `sdram_write`  out  1: write command to `SDRAMBus`.
- `sdram_addr`  out  23: address to `SDRAMBus`.
- `sdram_writedata`  out  32: write data to `SDRAMBus`.
- `sdram_readdata`  in  32: read data from `SDRAMBus`.
- `sdram_finished`  in  1: one-cycle completion pulse from `SDRAMBus`.
- `o_grant`  out  3: index of the current or last granted client (debug/LED).
- `o_busy`  out  1: high in BUSY.
- `o_timeout`  out  1: sticky; set on a watchdog abort, cleared only by reset.

## Operation
- The FSM has three states: IDLE, BUSY and RELEASE.
- **IDLE:**
  - `req_any = |(req_read | req_write)`.
  - If `req_any` is high, grant g = the lowest index with a request. On the next edge:
    - latch g into `o_grant`;
    - latch the command, the address slice and the writedata slice into the output registers;
    - clear the watchdog counter;
    - go to BUSY.
- **Command rule:** if a client asserts both read and write, the write wins: `sdram_write`=1 and `sdram_read`=0.
- **BUSY:**
  - The command outputs are held constant, registered, regardless of any change on the client inputs.
  - Client inputs are ignored, including a higher-priority arrival; there is no preemption.
  - When `sdram_finished`=1:
    - combinationally, `req_finished[o_grant]`=1 and `req_readdata`=`sdram_readdata` in the same cycle;
    - on the next edge, `sdram_read`/`sdram_write` go to 0 and the FSM goes to RELEASE.
  - The watchdog counter increments each BUSY cycle. When it reaches TIMEOUT-1 without `sdram_finished`:
    - pulse `req_finished[o_grant]` with `req_readdata`=0;
    - set `o_timeout`;
    - clear the commands on the next edge and go to RELEASE.
- **RELEASE:** lasts one cycle. All commands are 0 and no grant is made. This gives the finished client one cycle to drop its request. Then go to IDLE.
- **Outside BUSY:** `req_finished`=0 and `req_readdata`=0.
- **Address and data:** passed through unmodified; the arbiter does no arithmetic on them.

## Timing
- **Reset values (asynchronous, effective immediately):**
  - `sdram_read`, `sdram_write`=0; `sdram_addr`, `sdram_writedata`=0;
  - `o_grant`=0, `o_busy`=0, `o_timeout`=0;
  - `req_finished`=0, `req_readdata`=0;
  - state = IDLE, watchdog counter = 0.
- **Reset mid-transaction:** the command drops at once and no `req_finished` pulse is issued. Clients are reset by the same `i_rst`.
- **Grant latency:** a request sampled high in IDLE at edge k gives the command on the bus from cycle k+1.
- **Completion latency:** `req_finished` appears in the same cycle as `sdram_finished` (combinational path).
- **Back-to-back service:** with `sdram_finished` at cycle F, the bus sees no command at F+1 and F+2 (RELEASE, then IDLE sampling). The earliest next command is at F+3.
- **Throughput:** at most one transaction per (bus latency + 3) cycles.
- **Spurious completion:** an `sdram_finished` pulse in IDLE or RELEASE is ignored; no `req_finished` is raised.
- **Starvation:** the load client can starve while play or record request continuously. This is accepted, because the real-time clients must win.

## Test plan
- **Single read:** client 0 read, addr 0x000123; bus finishes 4 cycles after the command with readdata 0xDEADBEEF. Required: `sdram_read`=1, `sdram_addr`=0x000123 one cycle after the request; `req_finished`=5'b00001 with `req_readdata`=0xDEADBEEF in the finish cycle; command 0 on the next cycle.
- **Priority:** clients 1 (write, addr 0x10, data 0xA5A5A5A5) and 4 (read, addr 0x20) request in the same cycle. Required: client 1 granted first (`o_grant`=1); client 4 gets its command exactly 3 cycles after client 1's finish.
- **No preemption:** client 3 is in BUSY when client 0 asserts. Required: `sdram_addr` stays at client 3's value until finish; client 0 is served next.
- **Read+write conflict:** client 2 asserts both, with data 0x12345678. Required: `sdram_write`=1, `sdram_read`=0, `sdram_writedata`=0x12345678.
- **Watchdog:** with TIMEOUT=16, the bus never finishes. Required: `req_finished` pulses for the granted client 16 cycles after grant; `o_timeout` goes to 1 and stays 1; the next request is served normally.
- **Async reset in BUSY:** `i_rst` pulses mid-transaction. Required: `sdram_read`/`sdram_write` go to 0 and `o_busy`=0 before the next clock edge; no `req_finished` pulse.
